// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared types and constants for the VGA raster generator:
//   vga_timing_t    : per-axis active/front-porch/sync/back-porch widths and
//                     sync polarities
//   VGA_640x480_60  : default 640x480 @ 60 Hz timing preset
//   SVGA_800x600_60 : 800x600 @ 60 Hz timing preset
//   rgb_t           : {B,G,R} pixel with 8-bit channels
//   bar_mask_t      : per-channel on/off mask for one colour bar
//   bar_mask()      : colour-bar lookup from a 3-bit bar index
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
      bit h_pol;
      bit v_pol;
   } vga_timing_t;

   localparam vga_timing_t VGA_640x480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
      h_pol: 1'b0,   v_pol: 1'b0
   };

   localparam vga_timing_t SVGA_800x600_60 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
      h_pol: 1'b1,   v_pol: 1'b1
   };

   localparam int RGB_CW = 8;

   typedef struct packed {
      logic [RGB_CW-1:0] b;
      logic [RGB_CW-1:0] g;
      logic [RGB_CW-1:0] r;
   } rgb_t;

   typedef struct packed {
      logic b;
      logic g;
      logic r;
   } bar_mask_t;

   // Bar index bits map straight onto channels, giving the classic
   // black/red/green/yellow/blue/magenta/cyan/white sequence left to right.
   function automatic bar_mask_t bar_mask(input logic [2:0] idx);
      bar_mask_t m;
      m.r = idx[0];
      m.g = idx[1];
      m.b = idx[2];
      return m;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bus between the raster generator, its pixel source and the DAC.
//   req/x/y            : pixel fetch request towards the frame buffer
//   frame_start        : pulse with the request for pixel (0,0)
//   line_start         : pulse with the request for x=0 of each visible line
//   color              : {B,G,R} returned by the pixel source
//   vga_r/g/b          : colour to the DAC
//   h_sync/v_sync      : sync outputs
//   blank_n            : high while the output pixel is visible
// master = generator side, slave = pixel source / DAC side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 10,
   parameter int CW = 8
);

   logic            req;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            frame_start;
   logic            line_start;
   logic [3*CW-1:0] color;
   logic [CW-1:0]   vga_r;
   logic [CW-1:0]   vga_g;
   logic [CW-1:0]   vga_b;
   logic            h_sync;
   logic            v_sync;
   logic            blank_n;

   modport master (
      output req, x, y, frame_start, line_start,
      input  color,
      output vga_r, vga_g, vga_b, h_sync, v_sync, blank_n
   );

   modport slave (
      input  req, x, y, frame_start, line_start,
      output color,
      input  vga_r, vga_g, vga_b, h_sync, v_sync, blank_n
   );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_delay_line
// Enabled shift register with synchronous clear.
//   clk   : clock
//   rst_n : synchronous active-low clear of every stage
//   en    : shift enable
//   d     : W-bit input
//   q     : W-bit output, d delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module vga_timing_gen_delay_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [DEPTH];

   // All stages clear together so nothing stale reaches the output after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster generator. Requests pixels from a frame-buffer
// source ahead of the display, then emits RGB/sync/blank aligned with the
// colour the source returns PIX_LAT enabled cycles later.
//   clk     : pixel-domain clock
//   rst_n   : synchronous active-low reset
//   en      : pixel enable; all state advances only when high
//   pattern : 1 = colour bars instead of returned colour
//   bus     : master side of vga_timing_gen_if (fetch request, returned
//             colour, DAC colour, syncs, blank)
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int H_ACTIVE = VGA_640x480_60.h_active,
   parameter int H_FP     = VGA_640x480_60.h_fp,
   parameter int H_SYNC   = VGA_640x480_60.h_sync,
   parameter int H_BP     = VGA_640x480_60.h_bp,
   parameter int V_ACTIVE = VGA_640x480_60.v_active,
   parameter int V_FP     = VGA_640x480_60.v_fp,
   parameter int V_SYNC   = VGA_640x480_60.v_sync,
   parameter int V_BP     = VGA_640x480_60.v_bp,
   parameter bit H_POL    = VGA_640x480_60.h_pol,
   parameter bit V_POL    = VGA_640x480_60.v_pol,
   parameter int PIX_LAT  = 2,
   parameter int CW       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              pattern,
   vga_timing_gen_if.master  bus
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW    = $clog2(H_TOT);
   localparam int YW    = $clog2(V_TOT);
   localparam int DW    = 6;

   localparam logic [XW-1:0] H_LAST     = XW'(H_TOT - 1);
   localparam logic [XW-1:0] H_VIS_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] V_LAST     = YW'(V_TOT - 1);
   localparam logic [YW-1:0] V_VIS_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [XW+2:0] BAR_DIV    = (XW+3)'(H_ACTIVE);

   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic          vis;
   logic          hs_raw;
   logic          vs_raw;
   logic [2:0]    bar_idx;
   logic          vis_d;
   logic          hs_d;
   logic          vs_d;
   logic [2:0]    bar_d;
   bar_mask_t     bar_m;
   logic [CW-1:0] red;
   logic [CW-1:0] green;
   logic [CW-1:0] blue;

   // Raster position of the pixel being requested; the line counter only
   // moves when the column counter wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
         end else begin
            h_cnt <= h_cnt + XW'(1);
         end
      end
   end

   // Request-side decode. The bar index is only meaningful while visible,
   // where x*8/H_ACTIVE always fits in three bits.
   always_comb begin
      vis     = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      hs_raw  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      vs_raw  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
      bar_idx = 3'({h_cnt, 3'b000} / BAR_DIV);
   end

   assign bus.req         = vis & en;
   assign bus.x           = h_cnt;
   assign bus.y           = v_cnt;
   assign bus.frame_start = en && (h_cnt == '0) && (v_cnt == '0);
   assign bus.line_start  = en && (h_cnt == '0) && (v_cnt < V_VIS_END);

   // Timing sidebands travel alongside the fetch so they emerge in the same
   // cycle the source presents the matching colour.
   vga_timing_gen_delay_line #(
      .W     (DW),
      .DEPTH (PIX_LAT)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     ({vis, hs_raw, vs_raw, bar_idx}),
      .q     ({vis_d, hs_d, vs_d, bar_d})
   );

   assign bar_m = bar_mask(bar_d);

   // Output colour: forced black in blanking, otherwise bars or the
   // returned {B,G,R} word; pattern is applied at this stage so it switches
   // on the very pixel being shown.
   always_comb begin
      red   = '0;
      green = '0;
      blue  = '0;
      if (vis_d) begin
         if (pattern) begin
            red   = {CW{bar_m.r}};
            green = {CW{bar_m.g}};
            blue  = {CW{bar_m.b}};
         end else begin
            red   = bus.color[CW-1:0];
            green = bus.color[2*CW-1:CW];
            blue  = bus.color[3*CW-1:2*CW];
         end
      end
   end

   assign bus.vga_r   = red;
   assign bus.vga_g   = green;
   assign bus.vga_b   = blue;
   assign bus.h_sync  = hs_d ? H_POL : ~H_POL;
   assign bus.v_sync  = vs_d ? V_POL : ~V_POL;
   assign bus.blank_n = vis_d;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen using a shrunken raster (16+2+3+3 pixels
// by 6+1+2+1 lines, 240-cycle frame) so whole frames fit in a short run.
// A second instance runs with positive sync polarity. A two-stage pixel
// source returns {y, x, 8'hA5} for each requested pixel.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
   import vga_timing_gen_pkg::*;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = 24;
   localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = 10;
   localparam int FT = HT * VT;
   localparam int XW = 5, YW = 4, CW = 8;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic en      = 1'b0;
   logic pattern = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [3*CW-1:0] src1;
   logic [3*CW-1:0] src2;

   vga_timing_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();
   vga_timing_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bus_p ();

   assign bus.color   = src2;
   assign bus_p.color = src2;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(2), .CW(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern(pattern), .bus(bus)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b1), .V_POL(1'b1), .PIX_LAT(2), .CW(CW)
   ) dut_p (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern(pattern), .bus(bus_p)
   );

   always #5 clk = ~clk;

   // Frame-buffer stand-in: colour for a request appears two enabled cycles later.
   always @(posedge clk) begin
      if (en) begin
         src1 <= {8'(bus.y), 8'(bus.x), 8'hA5};
         src2 <= src1;
      end
   end

   // Safety net in case something stalls the clock loop.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit exp_vis(input int p);
      return (p >= 0) && ((p % HT) < HA) && (((p / HT) % VT) < VA);
   endfunction

   function automatic bit exp_hs(input int p);
      return (p >= 0) && ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
   endfunction

   function automatic bit exp_vs(input int p);
      int l;
      l = (p / HT) % VT;
      return (p >= 0) && (l >= VA + VF) && (l < VA + VF + VS);
   endfunction

   function automatic rgb_t exp_rgb(input int p);
      rgb_t c;
      c = '0;
      if (exp_vis(p)) begin
         c.b = 8'((p / HT) % VT);
         c.g = 8'(p % HT);
         c.r = 8'hA5;
      end
      return c;
   endfunction

   task automatic tick(input logic e, input logic p);
      @(negedge clk);
      en      = e;
      pattern = p;
      #1;
   endtask

   // Leaves the bench sampling cycle 0 after release.
   task automatic do_reset();
      rst_n = 1'b0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rgb_t got;
      do_reset();
      checks++; if (bus.req !== 1'b1) begin errors++; $display("[TB] FAIL reset_req: got %b expected 1", bus.req); end
      checks++; if (bus.x !== 5'd0 || bus.y !== 4'd0) begin errors++; $display("[TB] FAIL reset_xy: got %0d,%0d expected 0,0", bus.x, bus.y); end
      checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL reset_frame_start: got %b expected 1", bus.frame_start); end
      checks++; if (bus.line_start !== 1'b1) begin errors++; $display("[TB] FAIL reset_line_start: got %b expected 1", bus.line_start); end
      checks++; if (bus.blank_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_blank0: got %b expected 0", bus.blank_n); end
      checks++; if (bus.h_sync !== 1'b1 || bus.v_sync !== 1'b1) begin errors++; $display("[TB] FAIL reset_sync_low_pol: got %b%b expected 11", bus.h_sync, bus.v_sync); end
      checks++; if (bus_p.h_sync !== 1'b0 || bus_p.v_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_high_pol: got %b%b expected 00", bus_p.h_sync, bus_p.v_sync); end
      tick(1'b1, 1'b0);
      checks++; if (bus.blank_n !== 1'b0 || bus.x !== 5'd1 || bus.frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_cycle1: got blank %b x %0d fs %b expected 0 1 0", bus.blank_n, bus.x, bus.frame_start); end
      tick(1'b1, 1'b0);
      got = {bus.vga_b, bus.vga_g, bus.vga_r};
      checks++; if (bus.blank_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_blank_rise: got %b expected 1", bus.blank_n); end
      checks++; if (got !== 24'h0000A5) begin errors++; $display("[TB] FAIL reset_first_pixel: got %h expected 0000a5", got); end
   endtask

   task automatic test_line_timing();
      int req_cnt = 0, blank_hi = 0, hs_lo = 0, hsp_hi = 0;
      int rise = -1, hs_first = -1, hsp_first = -1;
      do_reset();
      for (int n = 0; n < 26; n++) begin
         if (n > 0) tick(1'b1, 1'b0);
         if (n < HT && bus.req === 1'b1) req_cnt++;
         if (n >= 2) begin
            if (bus.blank_n === 1'b1) begin blank_hi++; if (rise < 0) rise = n; end
            if (bus.h_sync === 1'b0) begin hs_lo++; if (hs_first < 0) hs_first = n; end
            if (bus_p.h_sync === 1'b1) begin hsp_hi++; if (hsp_first < 0) hsp_first = n; end
         end
      end
      checks++; if (req_cnt != 16) begin errors++; $display("[TB] FAIL line_req_count: got %0d expected 16", req_cnt); end
      checks++; if (blank_hi != 16) begin errors++; $display("[TB] FAIL line_blank_high: got %0d expected 16", blank_hi); end
      checks++; if (rise != 2) begin errors++; $display("[TB] FAIL line_blank_rise: got %0d expected 2", rise); end
      checks++; if (hs_lo != 3) begin errors++; $display("[TB] FAIL line_hsync_width: got %0d expected 3", hs_lo); end
      checks++; if (hs_first - rise != 18) begin errors++; $display("[TB] FAIL line_hsync_offset: got %0d expected 18", hs_first - rise); end
      checks++; if (hsp_hi != 3 || hsp_first != 20) begin errors++; $display("[TB] FAIL line_hsync_pos_pol: got %0d at %0d expected 3 at 20", hsp_hi, hsp_first); end
   endtask

   task automatic test_frame_timing();
      int fs_cnt = 0, ls_cnt = 0, vs_lo = 0, vs_first = -1;
      int fs_idx [3] = '{-1, -1, -1};
      do_reset();
      for (int n = 0; n <= 2 * FT; n++) begin
         if (n > 0) tick(1'b1, 1'b0);
         if (bus.frame_start === 1'b1) begin
            if (fs_cnt < 3) fs_idx[fs_cnt] = n;
            fs_cnt++;
         end
         if (n < FT && bus.line_start === 1'b1) ls_cnt++;
         if (n >= 2 && n < FT + 2 && bus.v_sync === 1'b0) begin
            vs_lo++;
            if (vs_first < 0) vs_first = n;
         end
      end
      checks++; if (fs_cnt != 3) begin errors++; $display("[TB] FAIL frame_start_count: got %0d expected 3", fs_cnt); end
      checks++; if (fs_idx[1] != FT || fs_idx[2] != 2 * FT) begin errors++; $display("[TB] FAIL frame_period: got %0d,%0d expected %0d,%0d", fs_idx[1], fs_idx[2], FT, 2 * FT); end
      checks++; if (ls_cnt != VA) begin errors++; $display("[TB] FAIL line_start_count: got %0d expected %0d", ls_cnt, VA); end
      checks++; if (vs_lo != 2 * HT) begin errors++; $display("[TB] FAIL vsync_width: got %0d expected %0d", vs_lo, 2 * HT); end
      checks++; if (vs_first != 2 + 7 * HT) begin errors++; $display("[TB] FAIL vsync_start: got %0d expected %0d", vs_first, 2 + 7 * HT); end
   endtask

   task automatic test_color();
      rgb_t got, exp;
      int p;
      do_reset();
      for (int n = 0; n < FT + 2; n++) begin
         if (n > 0) tick(1'b1, 1'b0);
         p   = n - 2;
         got = {bus.vga_b, bus.vga_g, bus.vga_r};
         exp = exp_rgb(p);
         checks++; if (got !== exp) begin errors++; $display("[TB] FAIL color_rgb@%0d: got %h expected %h", n, got, exp); end
         checks++; if (bus.blank_n !== exp_vis(p)) begin errors++; $display("[TB] FAIL color_blank@%0d: got %b expected %b", n, bus.blank_n, exp_vis(p)); end
         checks++; if (bus.h_sync !== !exp_hs(p) || bus.v_sync !== !exp_vs(p)) begin errors++; $display("[TB] FAIL color_sync@%0d: got %b%b expected %b%b", n, bus.h_sync, bus.v_sync, !exp_hs(p), !exp_vs(p)); end
      end
   endtask

   task automatic test_enable();
      rgb_t got, exp;
      int s, fs_cnt = 0;
      logic e;
      do_reset();
      for (int n = 0; n <= 4 * FT; n++) begin
         e = (n % 2 == 0);
         if (n > 0) tick(e, 1'b0);
         s   = (n + 1) / 2;
         got = {bus.vga_b, bus.vga_g, bus.vga_r};
         exp = exp_rgb(s - 2);
         if (bus.frame_start === 1'b1) fs_cnt++;
         checks++; if (got !== exp || bus.blank_n !== exp_vis(s - 2)) begin errors++; $display("[TB] FAIL enable_out@%0d: got %h/%b expected %h/%b", n, got, bus.blank_n, exp, exp_vis(s - 2)); end
         checks++; if (bus.req !== (e && exp_vis(s))) begin errors++; $display("[TB] FAIL enable_req@%0d: got %b expected %b", n, bus.req, e && exp_vis(s)); end
         if (e && exp_vis(s)) begin
            checks++; if (bus.x !== XW'(s % HT)) begin errors++; $display("[TB] FAIL enable_x@%0d: got %0d expected %0d", n, bus.x, s % HT); end
         end
         checks++; if (bus.frame_start !== (e && (s % FT == 0))) begin errors++; $display("[TB] FAIL enable_frame_start@%0d: got %b expected %b", n, bus.frame_start, e && (s % FT == 0)); end
      end
      checks++; if (fs_cnt != 3) begin errors++; $display("[TB] FAIL enable_frame_count: got %0d expected 3", fs_cnt); end
   endtask

   task automatic test_reset_mid_pattern();
      rgb_t got;
      do_reset();
      for (int n = 1; n <= 82; n++) tick(1'b1, 1'b0);
      checks++; if (bus.blank_n !== 1'b1 || bus.x !== 5'd10 || bus.y !== 4'd3) begin errors++; $display("[TB] FAIL mid_before: got blank %b xy %0d,%0d expected 1 10,3", bus.blank_n, bus.x, bus.y); end
      rst_n = 1'b0;
      tick(1'b1, 1'b0);
      got = {bus.vga_b, bus.vga_g, bus.vga_r};
      checks++; if (got !== 24'h0 || bus.blank_n !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_out: got %h/%b expected 000000/0", got, bus.blank_n); end
      checks++; if (bus.h_sync !== 1'b1 || bus.v_sync !== 1'b1 || bus_p.h_sync !== 1'b0 || bus_p.v_sync !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_sync: got %b%b%b%b expected 1100", bus.h_sync, bus.v_sync, bus_p.h_sync, bus_p.v_sync); end
      rst_n = 1'b1;
      checks++; if (bus.frame_start !== 1'b1 || bus.x !== 5'd0 || bus.y !== 4'd0) begin errors++; $display("[TB] FAIL mid_restart: got fs %b xy %0d,%0d expected 1 0,0", bus.frame_start, bus.x, bus.y); end
      for (int n = 1; n <= 27; n++) begin
         tick(1'b1, n <= 18);
         got = {bus.vga_b, bus.vga_g, bus.vga_r};
         case (n)
            2:  begin checks++; if (got !== 24'h000000 || bus.blank_n !== 1'b1) begin errors++; $display("[TB] FAIL bar_x0: got %h/%b expected 000000/1", got, bus.blank_n); end end
            4:  begin checks++; if (got !== 24'h0000FF) begin errors++; $display("[TB] FAIL bar_x2: got %h expected 0000ff", got); end end
            6:  begin checks++; if (got !== 24'h00FF00) begin errors++; $display("[TB] FAIL bar_x4: got %h expected 00ff00", got); end end
            11: begin checks++; if (got !== 24'hFF0000) begin errors++; $display("[TB] FAIL bar_x9: got %h expected ff0000", got); end end
            17: begin checks++; if (got !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL bar_x15: got %h expected ffffff", got); end end
            18: begin checks++; if (got !== 24'h000000 || bus.blank_n !== 1'b0) begin errors++; $display("[TB] FAIL bar_blank: got %h/%b expected 000000/0", got, bus.blank_n); end end
            27: begin checks++; if (got !== 24'h0101A5) begin errors++; $display("[TB] FAIL bar_off: got %h expected 0101a5", got); end end
            default: ;
         endcase
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_color();
      test_enable();
      test_reset_mid_pattern();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
